acc_stage: RTL and testbench

Accumulator stage of the 8-bit datapath. Holds the working register, sources the operand for the downstream bitwise-complement unit, and consumes its result. Executes LOAD, NOT, AND, OR, ADD, SUB and multi-cycle shifts under a valid/ready handshake, then updates Z/N/C flags. Sits between instruction decode (upstream) and the complement unit plus result consumers (downstream).

---
 rtl/acc_stage.sv | 182 ++++++++++++++++++
 tb/tb_acc_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_stage.sv
// acc_stage -- accumulator stage of the 8-bit datapath.
//
// Holds the working register (acc), presents it to the external complement
// unit on nx_out and takes the complemented value back on nz_in for NOT.
// Executes LOAD, NOT, AND, OR, ADD, SUB in one cycle and SHL/SHR one bit per
// cycle, then updates the Z/N/C flags.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  decode presents an operation
//   in_ready  stage can accept (high only while idle)
//   op        opcode, latched on accept
//   operand   operand / shift amount (bits [2:0]), latched on accept
//   nx_out    copy of acc, feeds the complement unit
//   nz_in     complement unit result, written to acc by NOT
//   acc       accumulator register
//   done      one-cycle pulse after each completed operation
//   flag_z    zero flag
//   flag_n    negative flag (acc MSB)
//   flag_c    carry flag (ADD, SUB, SHL, SHR only)
module acc_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] nx_out,
    input  logic [WIDTH-1:0] nz_in,
    output logic [WIDTH-1:0] acc,
    output logic             done,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_NOT  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_SHR  = 3'b111;

    state_t           state_r, state_s;
    logic [2:0]       cnt_r, cnt_s;
    logic             shr_r, shr_s;      // direction of the shift in flight
    logic [WIDTH-1:0] acc_r, acc_s;
    logic             flag_z_r, flag_z_s;
    logic             flag_n_r, flag_n_s;
    logic             flag_c_r, flag_c_s;
    logic             done_r, done_s;
    logic             upd_zn_s;          // an op completes this edge

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] shl_acc_s, shr_acc_s;
    logic             shl_out_s, shr_out_s;

    // The borrow of the 9-bit difference is the inverse of "acc >= operand".
    assign sum_s  = {1'b0, acc_r} + {1'b0, operand};
    assign diff_s = {1'b0, acc_r} - {1'b0, operand};
    assign {shl_out_s, shl_acc_s} = {acc_r, 1'b0};
    assign {shr_acc_s, shr_out_s} = {1'b0, acc_r};

    assign in_ready = (state_r == ST_IDLE);
    assign nx_out   = acc_r;
    assign acc      = acc_r;
    assign done     = done_r;
    assign flag_z   = flag_z_r;
    assign flag_n   = flag_n_r;
    assign flag_c   = flag_c_r;

    // Next-state, datapath and flag computation.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        shr_s    = shr_r;
        acc_s    = acc_r;
        flag_c_s = flag_c_r;
        flag_z_s = flag_z_r;
        flag_n_s = flag_n_r;
        done_s   = 1'b0;
        upd_zn_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    done_s   = 1'b1;
                    upd_zn_s = 1'b1;
                    case (op)
                        OP_LOAD: acc_s = operand;
                        OP_NOT:  acc_s = nz_in;
                        OP_AND:  acc_s = acc_r & operand;
                        OP_OR:   acc_s = acc_r | operand;
                        OP_ADD: begin
                            acc_s    = sum_s[WIDTH-1:0];
                            flag_c_s = sum_s[WIDTH];
                        end
                        OP_SUB: begin
                            acc_s    = diff_s[WIDTH-1:0];
                            flag_c_s = ~diff_s[WIDTH];
                        end
                        OP_SHL, OP_SHR: begin
                            if (operand[2:0] == 3'd0) begin
                                // Zero-length shift finishes now with C cleared.
                                flag_c_s = 1'b0;
                            end else begin
                                state_s  = ST_SHIFT;
                                cnt_s    = operand[2:0];
                                shr_s    = (op == OP_SHR);
                                done_s   = 1'b0;
                                upd_zn_s = 1'b0;
                            end
                        end
                        default: acc_s = acc_r;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                acc_s = shr_r ? shr_acc_s : shl_acc_s;
                cnt_s = cnt_r - 3'd1;
                if (cnt_r == 3'd1) begin
                    // The bit leaving on the final step is the carry.
                    state_s  = ST_IDLE;
                    done_s   = 1'b1;
                    upd_zn_s = 1'b1;
                    flag_c_s = shr_r ? shr_out_s : shl_out_s;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 3'd0;
            end
        endcase

        if (upd_zn_s) begin
            flag_z_s = (acc_s == {WIDTH{1'b0}});
            flag_n_s = acc_s[WIDTH-1];
        end else begin
            flag_z_s = flag_z_r;
            flag_n_s = flag_n_r;
        end
    end

    // State, accumulator, flag and done registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 3'd0;
            shr_r    <= 1'b0;
            acc_r    <= {WIDTH{1'b0}};
            flag_z_r <= 1'b0;
            flag_n_r <= 1'b0;
            flag_c_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            shr_r    <= shr_s;
            acc_r    <= acc_s;
            flag_z_r <= flag_z_s;
            flag_n_r <= flag_n_s;
            flag_c_r <= flag_c_s;
            done_r   <= done_s;
        end
    end

endmodule

// File: tb/tb_acc_stage.sv
// tb_acc_stage -- self-checking bench for acc_stage: directed scenarios plus
// randomized operations compared against an arithmetic reference model.
module tb_acc_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] operand;
    logic [7:0] nx_out;
    logic [7:0] nz_in;
    logic [7:0] acc;
    logic       done;
    logic       flag_z, flag_n, flag_c;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [7:0] m_acc;
    logic       m_z, m_n, m_c;

    acc_stage #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .operand  (operand),
        .nx_out   (nx_out),
        .nz_in    (nz_in),
        .acc      (acc),
        .done     (done),
        .flag_z   (flag_z),
        .flag_n   (flag_n),
        .flag_c   (flag_c)
    );

    // Clock generator.
    always #5 clk = ~clk;

    // Combinational complement unit.
    assign nz_in = ~nx_out;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, ".acc"}, acc, m_acc);
        check_eq({tag, ".nx_out"}, nx_out, m_acc);
        check_eq({tag, ".flags"}, {flag_z, flag_n, flag_c}, {m_z, m_n, m_c});
    endtask

    // Issue one op; called at posedge+1. With hold, in_valid stays high with
    // random garbage on op/operand after the accept.
    task automatic do_op(input logic [2:0] o, input logic [7:0] d, input bit hold);
        int         guard;
        int         n;
        logic [7:0] orig;
        logic [8:0] sum;
        logic [15:0] wide;
        in_valid = 1'b1;
        op       = o;
        operand  = d;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("ready_before_accept", in_ready, 1'b1);
        orig = m_acc;
        n    = (o >= 3'd6) ? int'(d[2:0]) : 0;
        @(posedge clk); #1;
        if (hold) begin
            op      = 3'($urandom);
            operand = 8'($urandom);
        end else begin
            in_valid = 1'b0;
        end

        case (o)
            3'd0: m_acc = d;
            3'd1: m_acc = ~m_acc;
            3'd2: m_acc = m_acc & d;
            3'd3: m_acc = m_acc | d;
            3'd4: begin
                sum   = 9'(m_acc) + 9'(d);
                m_acc = sum[7:0];
                m_c   = sum[8];
            end
            3'd5: begin
                m_c   = (m_acc >= d);
                m_acc = m_acc - d;
            end
            3'd6: begin
                wide = {8'h00, orig} << n;
                m_acc = wide[7:0];
                m_c   = (n == 0) ? 1'b0 : wide[8];
            end
            default: begin
                wide = {orig, 8'h00} >> n;
                m_acc = wide[15:8];
                m_c   = (n == 0) ? 1'b0 : wide[7];
            end
        endcase
        m_z = (m_acc == 8'h00);
        m_n = m_acc[7];

        for (int k = 1; k <= n; k++) begin
            check_eq("shift_ready_low", in_ready, 1'b0);
            check_eq("shift_done_low", done, 1'b0);
            if (o == 3'd6) check_eq("shift_step_acc", acc, 8'(orig << (k - 1)));
            else           check_eq("shift_step_acc", acc, 8'(orig >> (k - 1)));
            @(posedge clk); #1;
            if (hold) begin
                op      = 3'($urandom);
                operand = 8'($urandom);
            end else begin
                in_valid = 1'b0;
            end
        end
        check_eq("op_done", done, 1'b1);
        check_eq("op_ready", in_ready, 1'b1);
        check_model("op_result");
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_done_low", done, 1'b0);
        check_eq("idle_ready", in_ready, 1'b1);
        check_model("idle");
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        op       = 3'd0;
        operand  = 8'h00;
        m_acc = 8'h00; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0;
        #12;
        check_eq("reset_done", done, 1'b0);
        check_eq("reset_ready", in_ready, 1'b1);
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // LOAD then NOT back-to-back: done high on two consecutive cycles.
        do_op(3'd0, 8'h5A, 1'b0);
        do_op(3'd1, 8'h33, 1'b0);
        check_eq("not_acc_A5", acc, 8'hA5);
        idle_cycle();

        // ADD wrap to zero, then SUB borrow.
        do_op(3'd0, 8'hFF, 1'b0);
        do_op(3'd4, 8'h01, 1'b0);
        do_op(3'd5, 8'h01, 1'b0);

        // SHL by 3 and SHR by 1, then AND keeps C.
        do_op(3'd0, 8'h81, 1'b0);
        do_op(3'd6, 8'h03, 1'b0);
        do_op(3'd0, 8'h81, 1'b0);
        do_op(3'd7, 8'h01, 1'b0);
        do_op(3'd2, 8'h00, 1'b0);
        idle_cycle();

        // Held in_valid with changing garbage during a shift.
        do_op(3'd0, 8'h81, 1'b1);
        do_op(3'd6, 8'h05, 1'b1);
        do_op(3'd3, 8'h10, 1'b1);
        idle_cycle();

        // Zero-length shift clears C.
        do_op(3'd0, 8'hC3, 1'b0);
        do_op(3'd4, 8'hFF, 1'b0);
        do_op(3'd6, 8'hF8, 1'b0);
        do_op(3'd4, 8'hFF, 1'b0);
        do_op(3'd7, 8'h08, 1'b0);
        idle_cycle();

        // Asynchronous reset in the middle of a 7-bit shift.
        do_op(3'd0, 8'h81, 1'b0);
        in_valid = 1'b1; op = 3'd6; operand = 8'h07;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("midshift_acc", acc, 8'h02);
        #3 rst_n = 1'b0;
        #1;
        m_acc = 8'h00; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0;
        check_eq("rst_ready", in_ready, 1'b1);
        check_eq("rst_done", done, 1'b0);
        check_model("rst_mid_shift");
        @(posedge clk); #1;
        check_eq("rst_hold_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_done", done, 1'b0);
        check_model("post_rst");

        // Randomized operations.
        for (int i = 0; i < 300; i++) begin
            do_op(3'($urandom), 8'($urandom), ($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 4) == 0) idle_cycle();
        end
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
